// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding / hazard control slice:
// operand-mux select codes and the multiplier occupancy FSM states.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF     = 2'b00;
  localparam fwd_sel_t FWD_EX_MEM = 2'b01;
  localparam fwd_sel_t FWD_MEM_WB = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mult_state_t;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Pipeline-register view seen by the forwarding/hazard unit.
// master: the pipeline side that supplies register indices and
// control bits and consumes selects and stall/flush controls.
// slave: the hazard unit itself.
interface forward_hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);

  logic [REG_ADDR_W-1:0] if_id_rs1;
  logic [REG_ADDR_W-1:0] if_id_rs2;
  logic [REG_ADDR_W-1:0] id_ex_rs1;
  logic [REG_ADDR_W-1:0] id_ex_rs2;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic                  id_ex_mem_read;
  logic                  id_ex_is_mult;
  logic [REG_ADDR_W-1:0] ex_mem_rd;
  logic [REG_ADDR_W-1:0] mem_wb_rd;
  logic                  ex_mem_reg_write;
  logic                  mem_wb_reg_write;

  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  flush_ex;
  logic                  mult_busy;
  logic                  mult_done;

  modport master (
    output if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd,
           id_ex_mem_read, id_ex_is_mult, ex_mem_rd, mem_wb_rd,
           ex_mem_reg_write, mem_wb_reg_write,
    input  fwd_sel_a, fwd_sel_b, stall_if, stall_id, stall_ex,
           flush_ex, mult_busy, mult_done
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd,
           id_ex_mem_read, id_ex_is_mult, ex_mem_rd, mem_wb_rd,
           ex_mem_reg_write, mem_wb_reg_write,
    output fwd_sel_a, fwd_sel_b, stall_if, stall_id, stall_ex,
           flush_ex, mult_busy, mult_done
  );

endinterface

// File: rtl/mult_occupancy_ctr.sv
// Tracks how long a multiply has been sitting in EX. A multiply that
// enters EX holds the pipeline for MULT_LAT-1 cycles and then pulses
// mult_done in its final EX cycle so EX/MEM captures the product.
// MULT_LAT == 1 degenerates to a single-cycle op: no stall, done pulse
// whenever a multiply is in EX.
module mult_occupancy_ctr
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic is_mult,
  output logic mult_stall,
  output logic mult_busy,
  output logic mult_done
);

  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULT_LAT > 1) ? (MULT_LAT - 2) : 0);

  mult_state_t      state;
  mult_state_t      state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  // State and remaining-cycle counter; a reset mid-multiply simply abandons it.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and stall/done outputs; everything is forced low while in reset.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mult_stall = 1'b0;
    mult_busy  = 1'b0;
    mult_done  = 1'b0;

    case (state)
      IDLE: begin
        if (is_mult) begin
          if (MULT_LAT > 1) begin
            mult_stall = 1'b1;
            mult_busy  = 1'b1;
            cnt_n      = CNT_LOAD;
            state_n    = BUSY;
          end else begin
            mult_done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mult_stall = 1'b1;
          mult_busy  = 1'b1;
          cnt_n      = cnt - 1'b1;
        end else begin
          mult_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (!arst_n) begin
      mult_stall = 1'b0;
      mult_busy  = 1'b0;
      mult_done  = 1'b0;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding select generation plus load-use and multiplier hazard control.
// Optional build macro HAZARD_PERF_CNT_EN adds two 32-bit stall-cycle
// performance counters (load-use stalls and multiplier stalls).
module forward_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MULT_LAT   = 4
) (
  input  logic clk,
  input  logic arst_n,
  forward_hazard_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_ld_stall_cnt,
  output logic [31:0] perf_mult_stall_cnt
`endif
);

  // A producing stage forwards only if it writes, targets a non-x0 register
  // and that register is the one being read.
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  // The younger result (EX/MEM) has priority over the older one (MEM/WB).
  function automatic fwd_sel_t pick_sel(input logic [REG_ADDR_W-1:0] rs,
                                        input logic [REG_ADDR_W-1:0] ex_mem_rd,
                                        input logic                  ex_mem_we,
                                        input logic [REG_ADDR_W-1:0] mem_wb_rd,
                                        input logic                  mem_wb_we);
    if (fwd_hit(ex_mem_we, ex_mem_rd, rs))
      return FWD_EX_MEM;
    else if (fwd_hit(mem_wb_we, mem_wb_rd, rs))
      return FWD_MEM_WB;
    else
      return FWD_RF;
  endfunction

  logic load_use;
  logic mult_stall;
  logic mult_busy;
  logic mult_done;

  mult_occupancy_ctr #(
    .MULT_LAT(MULT_LAT)
  ) u_mult_occupancy_ctr (
    .clk        (clk),
    .arst_n     (arst_n),
    .is_mult    (bus.id_ex_is_mult),
    .mult_stall (mult_stall),
    .mult_busy  (mult_busy),
    .mult_done  (mult_done)
  );

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = bus.id_ex_mem_read && (bus.id_ex_rd != '0) &&
               ((bus.id_ex_rd == bus.if_id_rs1) || (bus.id_ex_rd == bus.if_id_rs2));
  end

  // Mux selects and stall/flush; a multiply holding EX overrides the load-use
  // bubble, which is picked up again once the multiplier lets go.
  always_comb begin
    bus.fwd_sel_a = pick_sel(bus.id_ex_rs1, bus.ex_mem_rd, bus.ex_mem_reg_write,
                             bus.mem_wb_rd, bus.mem_wb_reg_write);
    bus.fwd_sel_b = pick_sel(bus.id_ex_rs2, bus.ex_mem_rd, bus.ex_mem_reg_write,
                             bus.mem_wb_rd, bus.mem_wb_reg_write);
    bus.stall_if  = load_use || mult_stall;
    bus.stall_id  = load_use || mult_stall;
    bus.stall_ex  = mult_stall;
    bus.flush_ex  = load_use && !mult_stall;
    bus.mult_busy = mult_busy;
    bus.mult_done = mult_done;

    if (!arst_n) begin
      bus.fwd_sel_a = FWD_RF;
      bus.fwd_sel_b = FWD_RF;
      bus.stall_if  = 1'b0;
      bus.stall_id  = 1'b0;
      bus.stall_ex  = 1'b0;
      bus.flush_ex  = 1'b0;
      bus.mult_busy = 1'b0;
      bus.mult_done = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Stall-cycle counters; a cycle with both hazards is charged to the multiplier.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      perf_ld_stall_cnt   <= '0;
      perf_mult_stall_cnt <= '0;
    end else begin
      if (mult_stall)
        perf_mult_stall_cnt <= perf_mult_stall_cnt + 32'd1;
      else if (load_use)
        perf_ld_stall_cnt <= perf_ld_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit (MULT_LAT = 4): a vector table for
// the combinational forwarding / load-use behaviour, then hand-written
// sequences for the multiplier, its interaction with load-use, reset
// mid-multiply and, when HAZARD_PERF_CNT_EN is defined, the counters.
module tb_forward_hazard_unit;

  logic clk;
  logic arst_n;

  int total;
  int bad;

  forward_hazard_unit_if #(.REG_ADDR_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_ld_stall_cnt;
  logic [31:0] perf_mult_stall_cnt;
`endif

  forward_hazard_unit #(
    .REG_ADDR_W(5),
    .MULT_LAT  (4)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_ld_stall_cnt   (perf_ld_stall_cnt),
    .perf_mult_stall_cnt (perf_mult_stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] ex_rd;
    logic       ex_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mem_read;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic [1:0] e_sel_a;
    logic [1:0] e_sel_b;
    logic       e_stall_if;
    logic       e_stall_id;
    logic       e_stall_ex;
    logic       e_flush;
  } vec_t;

  vec_t vecs [10];

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.if_id_rs1        = '0;
    bus.if_id_rs2        = '0;
    bus.id_ex_rs1        = '0;
    bus.id_ex_rs2        = '0;
    bus.id_ex_rd         = '0;
    bus.id_ex_mem_read   = 1'b0;
    bus.id_ex_is_mult    = 1'b0;
    bus.ex_mem_rd        = '0;
    bus.mem_wb_rd        = '0;
    bus.ex_mem_reg_write = 1'b0;
    bus.mem_wb_reg_write = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.ex_mem_rd        = v.ex_rd;
    bus.ex_mem_reg_write = v.ex_we;
    bus.mem_wb_rd        = v.wb_rd;
    bus.mem_wb_reg_write = v.wb_we;
    bus.id_ex_rs1        = v.rs1;
    bus.id_ex_rs2        = v.rs2;
    bus.id_ex_mem_read   = v.mem_read;
    bus.id_ex_rd         = v.idex_rd;
    bus.if_id_rs1        = v.ifid_rs1;
    bus.if_id_rs2        = v.ifid_rs2;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //         ex_rd ex_we wb_rd wb_we rs1  rs2  mrd  idrd  ifr1  ifr2  sel_a  sel_b  sif  sid  sex  fl
    vecs[0] = '{5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 5'd9, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd9, 1'b1, 5'd2, 1'b0, 5'd2, 5'd9, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 5'd0, 1'b1, 5'd7, 5'd0, 5'd7, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd3, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd7, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 5'd6, 1'b1, 5'd7, 5'd6, 5'd8, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with hazards present on every input: outputs must all be low.
    arst_n = 1'b0;
    clearInputs();
    bus.ex_mem_rd        = 5'd5;
    bus.ex_mem_reg_write = 1'b1;
    bus.id_ex_rs1        = 5'd5;
    bus.id_ex_rs2        = 5'd5;
    bus.id_ex_mem_read   = 1'b1;
    bus.id_ex_rd         = 5'd7;
    bus.if_id_rs1        = 5'd7;
    bus.id_ex_is_mult    = 1'b1;
    nextCycle();
    nextCycle();
    #2;
    checkOutput("rst_sel_a",    32'(bus.fwd_sel_a), 32'd0);
    checkOutput("rst_sel_b",    32'(bus.fwd_sel_b), 32'd0);
    checkOutput("rst_stall_if", 32'(bus.stall_if),  32'd0);
    checkOutput("rst_stall_ex", 32'(bus.stall_ex),  32'd0);
    checkOutput("rst_flush_ex", 32'(bus.flush_ex),  32'd0);
    checkOutput("rst_busy",     32'(bus.mult_busy), 32'd0);
    checkOutput("rst_done",     32'(bus.mult_done), 32'd0);

    nextCycle();
    clearInputs();
    arst_n = 1'b1;
    #2;
    checkOutput("idle_busy", 32'(bus.mult_busy), 32'd0);

    // Combinational forwarding / load-use table.
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d_sel_a", i),    32'(bus.fwd_sel_a), 32'(vecs[i].e_sel_a));
      checkOutput($sformatf("v%0d_sel_b", i),    32'(bus.fwd_sel_b), 32'(vecs[i].e_sel_b));
      checkOutput($sformatf("v%0d_stall_if", i), 32'(bus.stall_if),  32'(vecs[i].e_stall_if));
      checkOutput($sformatf("v%0d_stall_id", i), 32'(bus.stall_id),  32'(vecs[i].e_stall_id));
      checkOutput($sformatf("v%0d_stall_ex", i), 32'(bus.stall_ex),  32'(vecs[i].e_stall_ex));
      checkOutput($sformatf("v%0d_flush_ex", i), 32'(bus.flush_ex),  32'(vecs[i].e_flush));
    end

    // Two back-to-back multiplies: 3 stall cycles then done, repeated with no gap.
    nextCycle();
    clearInputs();
    bus.id_ex_is_mult = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) nextCycle();
      #2;
      checkOutput($sformatf("mul_c%0d_stall_if", k), 32'(bus.stall_if),  ((k % 4) != 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("mul_c%0d_stall_ex", k), 32'(bus.stall_ex),  ((k % 4) != 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("mul_c%0d_busy", k),     32'(bus.mult_busy), ((k % 4) != 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("mul_c%0d_done", k),     32'(bus.mult_done), ((k % 4) == 3) ? 32'd1 : 32'd0);
      #0;
    end
    nextCycle();
    bus.id_ex_is_mult = 1'b0;
    #2;
    checkOutput("mul_after_busy",  32'(bus.mult_busy), 32'd0);
    checkOutput("mul_after_done",  32'(bus.mult_done), 32'd0);
    checkOutput("mul_after_stall", 32'(bus.stall_ex),  32'd0);

    // Multiply together with a load-use hazard: no flush until the multiply releases.
    nextCycle();
    bus.id_ex_is_mult  = 1'b1;
    bus.id_ex_mem_read = 1'b1;
    bus.id_ex_rd       = 5'd7;
    bus.if_id_rs2      = 5'd7;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) nextCycle();
      #2;
      checkOutput($sformatf("ml_c%0d_flush", k),    32'(bus.flush_ex), 32'd0);
      checkOutput($sformatf("ml_c%0d_stall_if", k), 32'(bus.stall_if), 32'd1);
      checkOutput($sformatf("ml_c%0d_stall_ex", k), 32'(bus.stall_ex), 32'd1);
    end
    nextCycle();
    #2;
    checkOutput("ml_c3_done",     32'(bus.mult_done), 32'd1);
    checkOutput("ml_c3_flush",    32'(bus.flush_ex),  32'd1);
    checkOutput("ml_c3_stall_id", 32'(bus.stall_id),  32'd1);
    checkOutput("ml_c3_stall_ex", 32'(bus.stall_ex),  32'd0);
    nextCycle();
    clearInputs();

    // Reset asserted in the second cycle of a multiply aborts it.
    nextCycle();
    bus.id_ex_is_mult = 1'b1;
    #2;
    checkOutput("rm_n_busy", 32'(bus.mult_busy), 32'd1);
    nextCycle();
    arst_n = 1'b0;
    #2;
    checkOutput("rm_n1_busy",  32'(bus.mult_busy), 32'd0);
    checkOutput("rm_n1_stall", 32'(bus.stall_if),  32'd0);
    nextCycle();
    arst_n = 1'b1;
    bus.id_ex_is_mult = 1'b0;
    #2;
    checkOutput("rm_n2_busy",  32'(bus.mult_busy), 32'd0);
    checkOutput("rm_n2_done",  32'(bus.mult_done), 32'd0);
    checkOutput("rm_n2_stall", 32'(bus.stall_ex),  32'd0);
    nextCycle();
    #2;
    checkOutput("rm_n3_done", 32'(bus.mult_done), 32'd0);
    checkOutput("rm_n3_busy", 32'(bus.mult_busy), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    // One multiply (3 stall cycles) followed by one load-use stall.
    nextCycle();
    arst_n = 1'b0;
    clearInputs();
    nextCycle();
    arst_n = 1'b1;
    #2;
    checkOutput("perf_rst_ld",   perf_ld_stall_cnt,   32'd0);
    checkOutput("perf_rst_mult", perf_mult_stall_cnt, 32'd0);
    nextCycle();
    bus.id_ex_is_mult = 1'b1;
    nextCycle();
    bus.id_ex_is_mult = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    bus.id_ex_mem_read = 1'b1;
    bus.id_ex_rd       = 5'd7;
    bus.if_id_rs1      = 5'd7;
    nextCycle();
    clearInputs();
    #2;
    checkOutput("perf_mult_cnt", perf_mult_stall_cnt, 32'd3);
    checkOutput("perf_ld_cnt",   perf_ld_stall_cnt,   32'd1);
`endif

    nextCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Control-side counterpart of the pipeline's 3-input operand muxes: produces their 2-bit select codes for ALU operands A and B, plus stall/flush control for load-use hazards and for the 4-cycle multiplier occupying EX. Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the hazard-control inputs of the PC, IF/ID and ID/EX registers.

## Interface
- REG_ADDR_W, 5, register-index width
- MULT_LAT, 4, EX-stage cycles a multiply occupies (legal 1..16)

- clk  in  1  core clock
- arst_n  in  1  reset, synchronous, active-low
- if_id_rs1, if_id_rs2  in  REG_ADDR_W  source registers of instruction in ID
- id_ex_rs1, id_ex_rs2  in  REG_ADDR_W  source registers of instruction in EX
- id_ex_rd  in  REG_ADDR_W  destination of instruction in EX
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_is_mult  in  1  instruction in EX is a multiply
- ex_mem_rd, mem_wb_rd  in  REG_ADDR_W  destinations in MEM / WB
- ex_mem_reg_write, mem_wb_reg_write  in  1  those stages write the register file
- fwd_sel_a, fwd_sel_b  out  2  operand mux selects
- stall_if, stall_id, stall_ex  out  1  hold PC+IF/ID, ID/EX, EX/MEM input
- flush_ex  out  1  insert bubble into ID/EX
- mult_busy  out  1  multiplier occupying EX, more cycles pending
- mult_done  out  1  one-cycle pulse: multiply leaves EX this cycle

## Operation
- Select encoding: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
- Operand A: 01 if ex_mem_reg_write & ex_mem_rd!=0 & ex_mem_rd==id_ex_rs1; else 10 if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==id_ex_rs1; else 00. Operand B identical on id_ex_rs2. EX/MEM wins over MEM/WB; x0 never forwarded.
- Load-use: id_ex_mem_read & id_ex_rd!=0 & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2) -> stall_if=stall_id=1, flush_ex=1 for that cycle.
- Multiplier FSM, states IDLE/BUSY, counter cnt ($clog2(MULT_LAT) bits):
  - IDLE & id_ex_is_mult & MULT_LAT>1: stall all (stall_if/id/ex=1), mult_busy=1, cnt<=MULT_LAT-2, ->BUSY.
  - BUSY & cnt!=0: stall all, mult_busy=1, cnt<=cnt-1.
  - BUSY & cnt==0: no mult stall, mult_done=1, ->IDLE.
  - MULT_LAT==1: FSM stays IDLE, mult_done=1 whenever id_ex_is_mult, no stall.
- Simultaneous mult stall and load-use: mult stall dominates; flush_ex forced 0 (EX is holding); load-use re-evaluated once mult releases.
- Forwarding selects stay live during stalls (operands re-muxed every cycle).

## Timing
- Selects, load-use stall/flush: combinational, same-cycle.
- Multiply entering EX in cycle N (MULT_LAT=4): stalls high N, N+1, N+2; mult_done high N+3; EX/MEM captures product at end of N+3.
- Reset: while arst_n low at a clk edge, state<=IDLE, cnt<=0; all outputs 0 (selects 00) while arst_n low. Reset mid-multiply aborts it; no mult_done issued.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs perf_ld_stall_cnt and perf_mult_stall_cnt (32 bits each), incrementing once per cycle of load-use stall / mult stall respectively, wrapping at 2^32-1 -> 0, cleared by reset. Cycle with both conditions counts only mult.
- Not defined: ports and counters absent; all other behaviour identical.

## Structure
- hazard_pkg: select constants FWD_RF, FWD_EX_MEM, FWD_MEM_WB; mult FSM state typedef (IDLE, BUSY).
- One sub-module: mult_occupancy_ctr (FSM + cnt, outputs mult_stall, mult_busy, mult_done); forwarding and load-use logic stay in top.

## Test plan
- ex_mem_rd=5 write, mem_wb_rd=5 write, id_ex_rs1=5, id_ex_rs2=5 -> fwd_sel_a=01, fwd_sel_b=01; drop ex_mem write -> both 10.
- ex_mem_rd=0 write, id_ex_rs1=0 -> fwd_sel_a=00.
- id_ex_mem_read, id_ex_rd=7, if_id_rs2=7 -> stall_if=stall_id=flush_ex=1 one cycle, stall_ex=0.
- id_ex_is_mult held, MULT_LAT=4 -> stalls 3 cycles, mult_done in 4th, then busy 0; back-to-back mult repeats pattern with no gap.
- Mult in BUSY plus load-use condition -> flush_ex=0 throughout; arst_n low in cycle N+1 -> next cycle mult_busy=0, no mult_done.
- HAZARD_PERF_CNT_EN: one mult (3 stalls) + one load-use -> perf_mult_stall_cnt=3, perf_ld_stall_cnt=1.
